// File: rtl/mdu_ctrl_if.sv
// Handshake and result bus between the EX stage and the multiply/divide controller.
// The EX side is the master: it issues work and reads back busy/done and HI/LO.
interface mdu_ctrl_if;
  logic        req;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs;
  logic [31:0] rt;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output req, start, op, rs, rt,
    input  busy, done, hi, lo
  );

  modport slave (
    input  req, start, op, rs, rt,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl.sv
// Fixed-latency multiply/divide controller that owns the HI/LO registers.
// Operands are latched at accept, and the result is written on the edge that ends the busy window.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, RUN} state_e;
  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} mdop_e;

  state_e             state_q, state_d;
  mdop_e              mdOp_q, mdOp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        srcA_q, srcA_d;
  logic [31:0]        srcB_q, srcB_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic [63:0]        prodSigned;
  logic [63:0]        prodUnsigned;
  logic               divByZero;
  logic [31:0]        safeDivisor;
  logic               negA, negB;
  logic [31:0]        magA, magB;
  logic [31:0]        quotMag, remMag;
  logic [31:0]        sQuot, sRem;
  logic [31:0]        uQuot, uRem;
  logic [31:0]        resHi, resLo;
  logic               resWrite;

  // Signed division runs on magnitudes so that 0x80000000 / -1 wraps back to 0x80000000.
  always_comb begin
    prodSigned   = $signed({{32{srcA_q[31]}}, srcA_q}) * $signed({{32{srcB_q[31]}}, srcB_q});
    prodUnsigned = {32'd0, srcA_q} * {32'd0, srcB_q};
    divByZero    = (srcB_q == 32'd0);
    safeDivisor  = divByZero ? 32'd1 : srcB_q;
    negA         = srcA_q[31];
    negB         = safeDivisor[31];
    magA         = negA ? (~srcA_q + 32'd1) : srcA_q;
    magB         = negB ? (~safeDivisor + 32'd1) : safeDivisor;
    quotMag      = magA / magB;
    remMag       = magA % magB;
    sQuot        = (negA ^ negB) ? (~quotMag + 32'd1) : quotMag;
    sRem         = negA ? (~remMag + 32'd1) : remMag;
    uQuot        = srcA_q / safeDivisor;
    uRem         = srcA_q % safeDivisor;
  end

  always_comb begin
    resHi    = 32'd0;
    resLo    = 32'd0;
    resWrite = 1'b1;
    case (mdOp_q)
      MD_MULT:  begin resHi = prodSigned[63:32];   resLo = prodSigned[31:0];   end
      MD_MULTU: begin resHi = prodUnsigned[63:32]; resLo = prodUnsigned[31:0]; end
      MD_DIV:   begin resHi = sRem; resLo = sQuot; resWrite = !divByZero; end
      default:  begin resHi = uRem; resLo = uQuot; resWrite = !divByZero; end
    endcase
  end

  assign accept = bus.start && !bus.req && (state_q == IDLE) && (bus.op <= 3'd5);

  always_comb begin
    state_d = state_q;
    mdOp_d  = mdOp_q;
    cnt_d   = cnt_q;
    srcA_d  = srcA_q;
    srcB_d  = srcB_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          case (bus.op)
            3'd4:    hi_d = bus.rs;
            3'd5:    lo_d = bus.rs;
            default: begin
              srcA_d  = bus.rs;
              srcB_d  = bus.rt;
              mdOp_d  = mdop_e'(bus.op[1:0]);
              cnt_d   = bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
          endcase
        end
      end
      RUN: begin
        // A req here is deliberately ignored: the instruction already left EX.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (resWrite) begin
            hi_d = resHi;
            lo_d = resLo;
          end
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mdOp_q  <= MD_MULT;
      cnt_q   <= '0;
      srcA_q  <= 32'd0;
      srcB_q  <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mdOp_q  <= mdOp_d;
      cnt_q   <= cnt_d;
      srcA_q  <= srcA_d;
      srcB_q  <= srcB_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios plus random traffic, every cycle compared
// against an arithmetic model that tracks completion by absolute edge number.
module tb_mdu_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset;
  mdu_ctrl_if bus ();

  mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model state: results become visible at edge finishEdge.
  int          edgeNum = 0;
  int          finishEdge = 0;
  bit          running = 0;
  bit          pendWrite = 0;
  logic [31:0] pendHi = 0, pendLo = 0;
  logic [31:0] hiM = 0, loM = 0;
  logic        busyM = 0, doneM = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, actual, expected, edgeNum);
    end
  endtask

  task automatic modelStep(input logic rstN, input logic st, input logic rq,
                           input logic [2:0] opv, input logic [31:0] a, input logic [31:0] b);
    longint          sp, sa, sb, sq, sr;
    longint unsigned up, ua, ub;
    edgeNum++;
    doneM = 0;
    if (!rstN) begin
      hiM = 0; loM = 0; running = 0; busyM = 0;
      return;
    end
    if (running) begin
      if (edgeNum == finishEdge) begin
        if (pendWrite) begin hiM = pendHi; loM = pendLo; end
        running = 0;
        doneM = 1;
      end
    end else if (st && !rq && opv <= 3'd5) begin
      pendWrite = 1;
      case (opv)
        3'd0: begin
          sp = longint'($signed(a)) * longint'($signed(b));
          pendHi = sp[63:32]; pendLo = sp[31:0];
        end
        3'd1: begin
          ua = 64'(a); ub = 64'(b); up = ua * ub;
          pendHi = up[63:32]; pendLo = up[31:0];
        end
        3'd2: begin
          if (b == 0) pendWrite = 0;
          else begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            sq = sa / sb; sr = sa % sb;
            pendLo = sq[31:0]; pendHi = sr[31:0];
          end
        end
        3'd3: begin
          if (b == 0) pendWrite = 0;
          else begin
            ua = 64'(a); ub = 64'(b);
            up = ua / ub; pendLo = up[31:0];
            up = ua % ub; pendHi = up[31:0];
          end
        end
        3'd4: hiM = a;
        default: loM = a;
      endcase
      if (opv <= 3'd3) begin
        running = 1;
        finishEdge = edgeNum + ((opv <= 3'd1) ? MULT_N : DIV_N);
      end
    end
    busyM = running;
  endtask

  // Drive one cycle of inputs, advance the model, then compare at the next falling edge.
  task automatic applyStimulus(input logic rstN, input logic st, input logic rq,
                               input logic [2:0] opv, input logic [31:0] a, input logic [31:0] b);
    reset     = rstN;
    bus.start = st;
    bus.req   = rq;
    bus.op    = opv;
    bus.rs    = a;
    bus.rt    = b;
    modelStep(rstN, st, rq, opv, a, b);
    @(negedge clk);
    checkOutput("busy", 32'(bus.busy), 32'(busyM));
    checkOutput("done", 32'(bus.done), 32'(doneM));
    checkOutput("hi", bus.hi, hiM);
    checkOutput("lo", bus.lo, loM);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom);
  endtask

  task automatic issue(input logic [2:0] opv, input logic [31:0] a, input logic [31:0] b);
    applyStimulus(1'b1, 1'b1, 1'b0, opv, a, b);
  endtask

  initial begin
    reset = 1'b0; bus.start = 1'b0; bus.req = 1'b0; bus.op = 3'd0; bus.rs = 32'd0; bus.rt = 32'd0;

    $display("[TB] reset held with start asserted");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'd5, 32'd7);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 32'd5, 32'd7);
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0, 32'd5, 32'd7);
    checkOutput("rstHi", bus.hi, 32'd0);
    checkOutput("rstLo", bus.lo, 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);

    $display("[TB] MULT -2 * 3");
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    idleCycles(MULT_N);
    checkOutput("multDone", 32'(bus.done), 32'd1);
    checkOutput("multHi", bus.hi, 32'hFFFFFFFF);
    checkOutput("multLo", bus.lo, 32'hFFFFFFFA);

    $display("[TB] MULTU then DIV");
    issue(3'd1, 32'hFFFFFFFF, 32'd2);
    idleCycles(MULT_N);
    checkOutput("multuHi", bus.hi, 32'd1);
    checkOutput("multuLo", bus.lo, 32'hFFFFFFFE);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    idleCycles(DIV_N);
    checkOutput("divLo", bus.lo, 32'hFFFFFFFD);
    checkOutput("divHi", bus.hi, 32'hFFFFFFFF);

    $display("[TB] DIV overflow and DIVU by zero");
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    idleCycles(DIV_N);
    checkOutput("ovfLo", bus.lo, 32'h80000000);
    checkOutput("ovfHi", bus.hi, 32'd0);
    issue(3'd4, 32'h11, 32'd0);
    issue(3'd5, 32'h22, 32'd0);
    issue(3'd3, 32'd1234, 32'd0);
    idleCycles(DIV_N);
    checkOutput("dz0Done", 32'(bus.done), 32'd1);
    checkOutput("dz0Hi", bus.hi, 32'h11);
    checkOutput("dz0Lo", bus.lo, 32'h22);

    $display("[TB] req interaction");
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd0, 32'd9, 32'd9);
    checkOutput("reqBusy", 32'(bus.busy), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, 3'd4, 32'hDEAD, 32'd0);
    checkOutput("reqMthi", bus.hi, 32'h11);
    issue(3'd2, 32'd100, 32'd7);
    for (int i = 1; i <= DIV_N; i++)
      applyStimulus(1'b1, 1'b0, (i == 3), 3'd0, $urandom, $urandom);
    checkOutput("reqRunLo", bus.lo, 32'd14);
    checkOutput("reqRunHi", bus.hi, 32'd2);

    $display("[TB] start while busy, then reset mid-run");
    issue(3'd0, 32'd3, 32'd4);
    for (int i = 1; i <= MULT_N; i++)
      applyStimulus(1'b1, (i == 2), 1'b0, 3'd0, 32'd100, 32'd100);
    checkOutput("dupDone", 32'(bus.done), 32'd1);
    checkOutput("dupLo", bus.lo, 32'd12);
    idleCycles(2);
    issue(3'd2, 32'd50, 32'd3);
    idleCycles(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    checkOutput("midRstBusy", 32'(bus.busy), 32'd0);
    checkOutput("midRstHi", bus.hi, 32'd0);
    checkOutput("midRstLo", bus.lo, 32'd0);
    idleCycles(DIV_N + 2);

    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      applyStimulus(($urandom_range(0, 79) != 0), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 6) == 0), 3'($urandom_range(0, 7)), a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
